axi4_lite_reg_bank: RTL and testbench
=====================================

Name: axi4_lite_reg_bank

Overview:
Parametrised AXI4-Lite slave holding a bank of NR_OF_REGS_P registers, each AXI_DATA_WIDTH_P wide.
- Per-register mode: read-write, read-only (value driven by hardware) or command (self-clearing pulse).
- Independent AW/W acceptance, byte-lane write strobes, SLVERR signalling and B/R backpressure.
- Sits between the AXI interconnect and any IP core's configuration/status logic.

Parameters:
- AXI_ADDR_WIDTH_P, 16, AXI address width.
- AXI_DATA_WIDTH_P, 32, data width; must be 32 or 64.
- NR_OF_REGS_P, 8, number of registers; must be at least 1.
- RO_MASK_P, '0, NR_OF_REGS_P bits; bit i=1 makes register i read-only.
- CMD_MASK_P, '0, NR_OF_REGS_P bits; bit i=1 makes register i a command register. RO takes priority if both bits are set.
- RESET_VALUE_P, '0, NR_OF_REGS_P*AXI_DATA_WIDTH_P bits; reset value of each RW register.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- awaddr  in  AXI_ADDR_WIDTH_P  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  AXI_DATA_WIDTH_P  write data
- wstrb  in  AXI_DATA_WIDTH_P/8  byte-lane strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  AXI_ADDR_WIDTH_P  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  AXI_DATA_WIDTH_P  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- reg_o  out  NR_OF_REGS_P*AXI_DATA_WIDTH_P  RW register contents, flattened, register i at slice i
- hw_i  in  NR_OF_REGS_P*AXI_DATA_WIDTH_P  read-only register values, flattened
- cmd_o  out  NR_OF_REGS_P*AXI_DATA_WIDTH_P  one-cycle command pulses
- wr_pulse_o  out  NR_OF_REGS_P  one-cycle strobe on a successful RW write

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values: all valid/ready/resp/rdata/cmd_o/wr_pulse_o are 0; reg_o = RESET_VALUE_P; AW and W holding buffers empty.
- Reset mid-transaction aborts it; no response is issued afterwards.
- Address decode: index = addr[AXI_ADDR_WIDTH_P-1:LSB], LSB = log2(AXI_DATA_WIDTH_P/8). Low bits are ignored (unaligned access treated as aligned).
- Index >= NR_OF_REGS_P is unmapped.
- AW channel: one-entry buffer; awready = !aw_full. Handshake captures awaddr and sets aw_full.
- W channel: one-entry buffer; wready = !w_full. Handshake captures wdata/wstrb and sets w_full.
- AW and W may arrive in either order or in the same cycle.
- Commit: when aw_full && w_full && (!bvalid || bready), the write executes on that edge. Both buffers clear and bvalid is set.
- Write latency: AW and W both present in cycle 0 → bvalid in cycle 2.
- Throughput: back-to-back writes sustain one write every 2 cycles with bready held at 1.
- Write effects:
  - RW register: each byte lane with wstrb=1 updated; wr_pulse_o[i]=1 for one cycle; bresp OKAY (00).
  - wstrb=0 on an RW register: no change, wr_pulse_o still pulses, OKAY.
  - CMD register: cmd_o slice = wdata masked by byte strobes for exactly one cycle, otherwise 0; nothing stored; OKAY.
  - RO register or unmapped address: no effect, bresp SLVERR (10).
- bvalid/bresp are held until bready.
- Read: arready = !rvalid. The handshake registers rdata/rresp, and rvalid rises the next cycle (1-cycle latency). Data is held stable until rready.
- Read data by register type:
  - RW: reg_o value before the edge; a read and a write committing in the same cycle returns the old value.
  - RO: hw_i sampled at the handshake.
  - CMD: 0.
  - Unmapped: BAADFACE repeated to width, rresp SLVERR.
- Read and write paths are fully independent.

Decomposition:
- Package axi4_lite_reg_bank_pkg:
  - AXI_RESP_OKAY_C, AXI_RESP_SLVERR_C, BAD_DATA_C.
  - reg_mode_t enum (RW, RO, CMD).
  - Function deriving the mode from the masks.
- No sub-module. The AW and W buffers are two small always_ff blocks; the decode is a package function.

Test Plan:
- Reset: assert rst mid-write with aw_full=1 → all outputs 0, reg_o=RESET_VALUE_P, no bvalid after release.
- RW byte write: awaddr=0x0004 and wdata=0xA1B2C3D4 with wstrb=0101, reg1 previously 0x11223344 → reg1=0x11B233D4, wr_pulse_o[1] one cycle, bresp=00, bvalid in cycle 2.
- Out-of-order channels: W three cycles before AW, bready=0 for 4 cycles → awready stays 0 after first AW until B drains, no data loss, single bresp=00.
- RO/unmapped: write 0x8 (reg2 RO) → SLVERR, hw_i unchanged. Read 0x40 with NR=8 → rdata=0xBAADFACE, rresp=10.
- CMD: write 0xC=0x00000005 → cmd_o[3] slice=5 for exactly one cycle; reading 0xC returns 0.
- Collision: read 0x0 in the same cycle as write 0x0 commits 0xDEADBEEF → rdata is the old value; next read returns 0xDEADBEEF. rready=0 for 3 cycles keeps rdata stable.

Source files
------------

// File: rtl/axi4_lite_reg_bank_pkg.sv
// Shared constants, register mode type and mode decode for the AXI4-Lite register bank.
package axi4_lite_reg_bank_pkg;

  localparam logic [1:0]  AXI_RESP_OKAY_C   = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR_C = 2'b10;
  // Returned for reads of unmapped addresses; the low bits are used for 32-bit buses.
  localparam logic [63:0] BAD_DATA_C        = 64'hBAAD_FACE_BAAD_FACE;

  typedef enum logic [1:0] {
    REG_RW,
    REG_RO,
    REG_CMD
  } reg_mode_t;

  // Read-only wins when a register is flagged both read-only and command.
  function automatic reg_mode_t reg_mode(input logic ro, input logic cmd);
    if (ro)  return REG_RO;
    if (cmd) return REG_CMD;
    return REG_RW;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave exposing a bank of RW / RO / command registers.
// Write address and data are buffered independently and commit together;
// the read path is a single registered stage, independent of writes.
module axi4_lite_reg_bank
  import axi4_lite_reg_bank_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH_P = 16,
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int NR_OF_REGS_P     = 8,
  parameter logic [NR_OF_REGS_P-1:0] RO_MASK_P  = '0,
  parameter logic [NR_OF_REGS_P-1:0] CMD_MASK_P = '0,
  parameter logic [NR_OF_REGS_P*AXI_DATA_WIDTH_P-1:0] RESET_VALUE_P = '0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [AXI_ADDR_WIDTH_P-1:0]                awaddr,
  input  logic                                       awvalid,
  output logic                                       awready,
  input  logic [AXI_DATA_WIDTH_P-1:0]                wdata,
  input  logic [AXI_DATA_WIDTH_P/8-1:0]              wstrb,
  input  logic                                       wvalid,
  output logic                                       wready,
  output logic [1:0]                                 bresp,
  output logic                                       bvalid,
  input  logic                                       bready,
  input  logic [AXI_ADDR_WIDTH_P-1:0]                araddr,
  input  logic                                       arvalid,
  output logic                                       arready,
  output logic [AXI_DATA_WIDTH_P-1:0]                rdata,
  output logic [1:0]                                 rresp,
  output logic                                       rvalid,
  input  logic                                       rready,
  output logic [NR_OF_REGS_P*AXI_DATA_WIDTH_P-1:0]   reg_o,
  input  logic [NR_OF_REGS_P*AXI_DATA_WIDTH_P-1:0]   hw_i,
  output logic [NR_OF_REGS_P*AXI_DATA_WIDTH_P-1:0]   cmd_o,
  output logic [NR_OF_REGS_P-1:0]                    wr_pulse_o
);

  localparam int DW    = AXI_DATA_WIDTH_P;
  localparam int SW    = DW / 8;
  localparam int LSB   = $clog2(SW);
  localparam int IDX_W = AXI_ADDR_WIDTH_P - LSB;

  logic [NR_OF_REGS_P-1:0][DW-1:0] reg_q;
  logic [NR_OF_REGS_P-1:0][DW-1:0] cmd_q;

  logic             aw_full;
  logic [IDX_W-1:0] aw_idx;
  logic             w_full;
  logic [DW-1:0]    w_data;
  logic [SW-1:0]    w_strb;

  logic [NR_OF_REGS_P-1:0] wr_sel;
  logic                    wr_err;
  logic [DW-1:0]           wmask;
  logic                    commit;

  logic [IDX_W-1:0] rd_idx;
  logic [DW-1:0]    rd_data_n;
  logic [1:0]       rd_resp_n;

  // Byte-offset address bits never take part in decode.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{awaddr[LSB-1:0], araddr[LSB-1:0]};

  // Ready is held low while in reset so nothing handshakes during it.
  assign awready = !aw_full && !rst;
  assign wready  = !w_full  && !rst;
  assign arready = !rvalid  && !rst;
  assign commit  = aw_full && w_full && (!bvalid || bready);
  assign reg_o   = reg_q;
  assign cmd_o   = cmd_q;
  assign rd_idx  = araddr[AXI_ADDR_WIDTH_P-1:LSB];

  // Write-address holding buffer: only the register index is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full <= 1'b0;
      aw_idx  <= '0;
    end else if (awvalid && awready) begin
      aw_full <= 1'b1;
      aw_idx  <= awaddr[AXI_ADDR_WIDTH_P-1:LSB];
    end else if (commit) begin
      aw_full <= 1'b0;
    end
  end

  // Write-data holding buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_full <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
    end else if (wvalid && wready) begin
      w_full <= 1'b1;
      w_data <= wdata;
      w_strb <= wstrb;
    end else if (commit) begin
      w_full <= 1'b0;
    end
  end

  // Decode the buffered write: one-hot select, error for RO/unmapped, byte mask.
  always_comb begin
    wr_sel = '0;
    wr_err = 1'b1;
    wmask  = '0;
    for (int i = 0; i < NR_OF_REGS_P; i++) begin
      if (aw_idx == IDX_W'(i)) begin
        wr_sel[i] = 1'b1;
        wr_err    = (reg_mode(RO_MASK_P[i], CMD_MASK_P[i]) == REG_RO);
      end
    end
    for (int b = 0; b < SW; b++) wmask[b*8 +: 8] = {8{w_strb[b]}};
  end

  // Commit writes into the bank, fire pulses and manage the B channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_q      <= RESET_VALUE_P;
      cmd_q      <= '0;
      wr_pulse_o <= '0;
      bvalid     <= 1'b0;
      bresp      <= AXI_RESP_OKAY_C;
    end else begin
      wr_pulse_o <= '0;
      cmd_q      <= '0;
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= wr_err ? AXI_RESP_SLVERR_C : AXI_RESP_OKAY_C;
        for (int i = 0; i < NR_OF_REGS_P; i++) begin
          if (wr_sel[i]) begin
            case (reg_mode(RO_MASK_P[i], CMD_MASK_P[i]))
              REG_RW: begin
                reg_q[i]      <= (reg_q[i] & ~wmask) | (w_data & wmask);
                wr_pulse_o[i] <= 1'b1;
              end
              REG_CMD: cmd_q[i] <= w_data & wmask;
              default: ;
            endcase
          end
        end
      end else if (bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read mux: stored value, live hardware value, zero for commands, or error pattern.
  always_comb begin
    rd_data_n = BAD_DATA_C[DW-1:0];
    rd_resp_n = AXI_RESP_SLVERR_C;
    for (int i = 0; i < NR_OF_REGS_P; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_resp_n = AXI_RESP_OKAY_C;
        case (reg_mode(RO_MASK_P[i], CMD_MASK_P[i]))
          REG_RW:  rd_data_n = reg_q[i];
          REG_RO:  rd_data_n = hw_i[i*DW +: DW];
          default: rd_data_n = '0;
        endcase
      end
    end
  end

  // Read response register, held until the master takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= AXI_RESP_OKAY_C;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rdata  <= rd_data_n;
      rresp  <= rd_resp_n;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Directed bench for axi4_lite_reg_bank: 8 x 32-bit, reg2 read-only, reg3 command.
module tb_axi4_lite_reg_bank;

  localparam int NR = 8;
  localparam int DW = 32;
  localparam logic [NR*DW-1:0] RST_V = {32'h0, 32'h0, 32'h0, 32'h0,
                                        32'h0, 32'h0, 32'h1122_3344, 32'hA5A5_0000};
  localparam logic [NR*DW-1:0] HW_V  = {32'hFFFF_FFF7, 32'hFFFF_FFF6, 32'hFFFF_FFF5, 32'hFFFF_FFF4,
                                        32'hFFFF_FFF3, 32'hCAFE_0002, 32'hFFFF_FFF1, 32'hFFFF_FFF0};

  logic            clk, rst;
  logic [15:0]     awaddr, araddr;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;
  logic [NR*DW-1:0] reg_o, hw_i, cmd_o;
  logic [NR-1:0]   wr_pulse_o;

  int n_chk = 0;
  int n_err = 0;

  axi4_lite_reg_bank #(
    .AXI_ADDR_WIDTH_P(16), .AXI_DATA_WIDTH_P(DW), .NR_OF_REGS_P(NR),
    .RO_MASK_P(8'h04), .CMD_MASK_P(8'h08), .RESET_VALUE_P(RST_V)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_o(reg_o), .hw_i(hw_i), .cmd_o(cmd_o), .wr_pulse_o(wr_pulse_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write with AW and W together, bready high; returns response and pulse seen with bvalid.
  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp, output logic [NR-1:0] pulse);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int n = 0; n < 10 && !bvalid; n++) tick();
    if (!bvalid) chk("wr_timeout", bvalid, 1);
    resp = bresp; pulse = wr_pulse_o;
    tick();
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int n = 0; n < 10 && !rvalid; n++) tick();
    if (!rvalid) chk("rd_timeout", rvalid, 1);
    d = rdata; resp = rresp;
    tick();
  endtask

  logic [1:0]      resp;
  logic [NR-1:0]   pulse;
  logic [31:0]     d, held;
  logic [NR*DW-1:0] e;

  initial begin
    rst = 1'b1; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; arvalid = 0;
    bready = 0; rready = 0; wdata = '0; wstrb = '0; hw_i = HW_V;
    #3;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_reg_o", reg_o, RST_V);
    chk("rst_cmd_o", cmd_o, 0);
    chk("rst_wr_pulse", wr_pulse_o, 0);
    tick(); rst = 1'b0; tick();
    chk("idle_awready", awready, 1);

    // RW byte-lane write: reg1 0x11223344, data A1B2C3D4, strobes 0101
    awaddr = 16'h0004; wdata = 32'hA1B2_C3D4; wstrb = 4'b0101;
    awvalid = 1; wvalid = 1; bready = 1;
    tick();
    chk("bw_c1_bvalid", bvalid, 0);
    chk("bw_c1_awready", awready, 0);
    awvalid = 0; wvalid = 0;
    tick();
    chk("bw_c2_bvalid", bvalid, 1);
    chk("bw_c2_bresp", bresp, 2'b00);
    chk("bw_c2_pulse", wr_pulse_o, 8'h02);
    chk("bw_reg1", reg_o[1*DW +: DW], 32'h11B2_33D4);
    tick();
    chk("bw_c3_pulse", wr_pulse_o, 0);
    chk("bw_c3_bvalid", bvalid, 0);

    // reset with a write address buffered
    awaddr = 16'h0000; awvalid = 1;
    tick();
    awvalid = 0;
    chk("mid_awready", awready, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_reg_o", reg_o, RST_V);
    chk("mid_bvalid", bvalid, 0);
    chk("mid_awready_rst", awready, 0);
    tick(); rst = 1'b0;
    tick(); tick(); tick();
    chk("mid_no_b", bvalid, 0);
    chk("mid_awready_free", awready, 1);

    // W three cycles ahead of AW, B held off
    bready = 0;
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    chk("ooo_wready", wready, 0);
    tick(); tick();
    chk("ooo_no_b_yet", bvalid, 0);
    awaddr = 16'h0000; awvalid = 1;
    tick();
    awvalid = 0;
    tick();
    chk("ooo_b1_valid", bvalid, 1);
    chk("ooo_b1_resp", bresp, 2'b00);
    chk("ooo_reg0", reg_o[0 +: DW], 32'h1234_5678);
    awaddr = 16'h0004; wdata = 32'h0000_0055; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    for (int k = 0; k < 4; k++) begin
      chk("ooo_hold_awready", awready, 0);
      chk("ooo_hold_bvalid", bvalid, 1);
      chk("ooo_hold_reg1", reg_o[1*DW +: DW], 32'h1122_3344);
      if (k < 3) tick();
    end
    bready = 1;
    tick();
    chk("ooo_b2_valid", bvalid, 1);
    chk("ooo_b2_awready", awready, 1);
    chk("ooo_reg1", reg_o[1*DW +: DW], 32'h0000_0055);
    tick();
    chk("ooo_b_drained", bvalid, 0);

    // read-only and unmapped
    wr(16'h0008, 32'hFFFF_FFFF, 4'hF, resp, pulse);
    chk("ro_wr_resp", resp, 2'b10);
    chk("ro_wr_pulse", pulse, 0);
    chk("ro_reg_o", reg_o[2*DW +: DW], 32'h0);
    rd(16'h0008, d, resp);
    chk("ro_rd_data", d, 32'hCAFE_0002);
    chk("ro_rd_resp", resp, 2'b00);
    rd(16'h0040, d, resp);
    chk("um_rd_data", d, 32'hBAAD_FACE);
    chk("um_rd_resp", resp, 2'b10);
    wr(16'h0040, 32'h1, 4'hF, resp, pulse);
    chk("um_wr_resp", resp, 2'b10);

    // zero strobes still pulse, no change; unaligned read decodes to reg1
    wr(16'h0004, 32'hFFFF_FFFF, 4'h0, resp, pulse);
    chk("z_wr_resp", resp, 2'b00);
    chk("z_wr_pulse", pulse, 8'h02);
    chk("z_reg1", reg_o[1*DW +: DW], 32'h0000_0055);
    rd(16'h0005, d, resp);
    chk("ua_rd_data", d, 32'h0000_0055);

    // command register pulse
    awaddr = 16'h000C; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    e = '0; e[3*DW +: DW] = 32'h5;
    chk("cmd_pulse", cmd_o, e);
    chk("cmd_bresp", bresp, 2'b00);
    chk("cmd_no_wr_pulse", wr_pulse_o, 0);
    tick();
    chk("cmd_cleared", cmd_o, 0);
    rd(16'h000C, d, resp);
    chk("cmd_rd_data", d, 32'h0);

    // read and write to reg0 on the same edge
    awaddr = 16'h0000; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    bready = 1; rready = 0;
    tick();
    awvalid = 0; wvalid = 0; araddr = 16'h0000; arvalid = 1;
    tick();
    arvalid = 0;
    chk("col_rvalid", rvalid, 1);
    chk("col_old_data", rdata, 32'h1234_5678);
    chk("col_reg0", reg_o[0 +: DW], 32'hDEAD_BEEF);
    held = rdata;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("col_hold_valid", rvalid, 1);
      chk("col_hold_data", rdata, 32'h1234_5678);
    end
    rready = 1;
    tick();
    chk("col_r_drained", rvalid, 0);
    rd(16'h0000, d, resp);
    chk("col_new_data", d, 32'hDEAD_BEEF);
    chk("col_held_once", held, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
